// File: rtl/vga_vidaddr_gen.sv
// vga_vidaddr_gen: turns raw horizontal/vertical timing strobes into
// polarity-corrected HSYNC/VSYNC/BLANK, pixel X/Y coordinates and the
// frame-buffer word-address stream, with a double-buffered video base
// address that swaps only on a frame boundary.
//
// Optional feature: define VGA_VIDADDR_STRIDE_EN to add the line_pad input.
// A line that carried active pixels then advances the address by line_pad
// at its end and restarts the sub-pixel counter. Without the macro the
// address stream is contiguous across lines.
//
// Address bookkeeping uses two registers. next_addr is the address of the
// word holding the next active pixel; it steps when the sub-pixel counter
// wraps. word_addr is the output copy, loaded from next_addr on each fetch
// and from the bank base at frame start. This keeps word_addr equal to the
// fetched word while word_req is high, even in 32bpp where the fetch and
// the wrap fall on the same pixel.
module vga_vidaddr_gen #(
  parameter int ADDR_W = 30,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              ena,
  input  logic              hsync_i,
  input  logic              hgate_i,
  input  logic              hdone_i,
  input  logic              vsync_i,
  input  logic              vgate_i,
  input  logic              vdone_i,
  input  logic              hpol,
  input  logic              vpol,
  input  logic              cpol,
  input  logic [1:0]        bpp,
  input  logic [ADDR_W-1:0] vba0,
  input  logic [ADDR_W-1:0] vba1,
  input  logic              swap_req,
`ifdef VGA_VIDADDR_STRIDE_EN
  input  logic [CNT_W-1:0]  line_pad,
`endif
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic [CNT_W-1:0]  px_x,
  output logic [CNT_W-1:0]  px_y,
  output logic [ADDR_W-1:0] word_addr,
  output logic              word_req,
  output logic              cur_bank,
  output logic              swap_ack,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sub_q, sub_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [CNT_W-1:0]  x_cnt, y_cnt;
  logic              line_active;
  logic              pend;

  logic              run;
  logic              act;
  logic              fetch;
  logic              sub_wrap;
  logic [1:0]        sub_lim;
  logic              frame_end;
  logic              start;
  logic              hline_end;
  logic              line_used;
  logic              base_bank;
  logic [ADDR_W-1:0] base;

  // Event decode: which strobes count this cycle, and the base of the bank
  // that will be on screen after a frame boundary.
  always_comb begin
    run       = (state_q == RUN);
    act       = ena & hgate_i & vgate_i & run;
    frame_end = ena & vdone_i & run;
    start     = ena & vdone_i & ~run;
    hline_end = ena & hdone_i & run;
    line_used = line_active | act;
    fetch     = act & (sub_q == 2'd0);
    case (bpp)
      2'b00:   sub_lim = 2'd3;
      2'b01:   sub_lim = 2'd1;
      default: sub_lim = 2'd0;
    endcase
    // Greater-or-equal lets a mid-line bpp change resynchronise at the
    // next sub==0 instead of running the 2-bit counter round.
    sub_wrap  = act & (sub_q >= sub_lim);
    base_bank = frame_end ? (cur_bank ^ pend) : cur_bank;
    base      = base_bank ? vba1 : vba0;
  end

  // Next-state logic: leave WAIT_FRAME on the first frame boundary.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    if (start) state_d = RUN;
  end

  // Sub-pixel counter and next-word pointer; later assignments override
  // earlier ones, so a frame boundary beats a line end beats a pixel.
  always_comb begin
    sub_d       = sub_q;
    next_addr_d = next_addr_q;
    if (act) begin
      sub_d = sub_wrap ? 2'd0 : sub_q + 2'd1;
      if (sub_wrap) next_addr_d = next_addr_q + ADDR_ONE;
    end
`ifdef VGA_VIDADDR_STRIDE_EN
    if (hline_end && !vdone_i && line_used) begin
      next_addr_d = next_addr_d + ADDR_W'(line_pad);
      sub_d       = 2'd0;
    end
`endif
    if (frame_end || start) begin
      sub_d       = 2'd0;
      next_addr_d = base;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_q <= WAIT_FRAME;
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    else         state_q <= state_d;
  end

  // Swap request flag: set on any cycle, consumed at frame end; a request
  // landing on the frame-end cycle itself carries over to the next frame.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)        pend <= 1'b0;
    else if (frame_end) pend <= swap_req;
    else if (swap_req)  pend <= 1'b1;
  end

  // Registered video outputs, address stream and bank state.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hsync       <= hpol;
      vsync       <= vpol;
      blank       <= ~cpol;
      word_req    <= 1'b0;
      swap_ack    <= 1'b0;
      frame_done  <= 1'b0;
      cur_bank    <= 1'b0;
      word_addr   <= '0;
      next_addr_q <= '0;
      sub_q       <= 2'd0;
    end else if (ena) begin
      hsync       <= run ? (hsync_i ^ hpol) : hpol;
      vsync       <= run ? (vsync_i ^ vpol) : vpol;
      blank       <= run ? (~(hgate_i & vgate_i) ^ cpol) : ~cpol;
      word_req    <= fetch;
      frame_done  <= frame_end;
      swap_ack    <= frame_end & pend;
      if (frame_end && pend) cur_bank <= ~cur_bank;
      if (fetch)                   word_addr <= next_addr_q;
      else if (frame_end || start) word_addr <= base;
      next_addr_q <= next_addr_d;
      sub_q       <= sub_d;
    end else begin
      word_req   <= 1'b0;
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  // Pixel coordinates: px_x/px_y report the pixel just presented, while
  // x_cnt/y_cnt hold the coordinate the next active pixel will get.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      px_x        <= '0;
      px_y        <= '0;
      line_active <= 1'b0;
    end else if (frame_end || start) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      px_x        <= '0;
      px_y        <= '0;
      line_active <= 1'b0;
    end else if (hline_end) begin
      x_cnt       <= '0;
      px_x        <= '0;
      line_active <= 1'b0;
      if (line_used) y_cnt <= y_cnt + CNT_ONE;
    end else if (act) begin
      px_x        <= x_cnt;
      px_y        <= y_cnt;
      x_cnt       <= x_cnt + CNT_ONE;
      line_active <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_vidaddr_gen.sv
// Scoreboard bench for vga_vidaddr_gen: stimulus pushes hand-computed fetch
// and frame-end expectations; a negedge monitor pops and compares them
// whenever the DUT raises word_req or frame_done.
module tb_vga_vidaddr_gen;

  localparam int AW = 30;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          nReset;
  logic          ena;
  logic          hsync_i, hgate_i, hdone_i;
  logic          vsync_i, vgate_i, vdone_i;
  logic          hpol, vpol, cpol;
  logic [1:0]    bpp;
  logic [AW-1:0] vba0, vba1;
  logic          swap_req;
  logic [CW-1:0] line_pad;
  logic          hsync, vsync, blank;
  logic [CW-1:0] px_x, px_y;
  logic [AW-1:0] word_addr;
  logic          word_req, cur_bank, swap_ack, frame_done;
  logic          ena_q = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] x;
    logic [31:0] y;
  } wexp_t;

  wexp_t      wq[$];
  logic [1:0] fq[$];   // {swap_ack, cur_bank} expected at each frame_done

  int checks = 0;
  int errors = 0;

  vga_vidaddr_gen #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .nReset(nReset), .ena(ena),
    .hsync_i(hsync_i), .hgate_i(hgate_i), .hdone_i(hdone_i),
    .vsync_i(vsync_i), .vgate_i(vgate_i), .vdone_i(vdone_i),
    .hpol(hpol), .vpol(vpol), .cpol(cpol), .bpp(bpp),
    .vba0(vba0), .vba1(vba1), .swap_req(swap_req),
`ifdef VGA_VIDADDR_STRIDE_EN
    .line_pad(line_pad),
`endif
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .px_x(px_x), .px_y(px_y), .word_addr(word_addr), .word_req(word_req),
    .cur_bank(cur_bank), .swap_ack(swap_ack), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_req(input logic [31:0] a, input logic [31:0] x, input logic [31:0] y);
    wexp_t e;
    e.addr = a;
    e.x    = x;
    e.y    = y;
    wq.push_back(e);
  endtask

  // ena as seen by the DUT at the most recent rising edge.
  always @(posedge clk) ena_q <= ena;

  // Monitor: compare every fetch and frame-end pulse against the queues.
  always @(negedge clk) begin
    if (word_req) begin
      check("req_on_ena", 32'(ena_q), 32'd1);
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word_req actual addr=%0h expected no request", word_addr);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        check("word_addr", 32'(word_addr), e.addr);
        check("px_x", 32'(px_x), e.x);
        check("px_y", 32'(px_y), e.y);
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done actual=1 expected=0");
      end else begin
        logic [1:0] f;
        f = fq.pop_front();
        check("swap_ack_bank", {30'd0, swap_ack, cur_bank}, {30'd0, f});
      end
    end else if (swap_ack) begin
      checks++;
      errors++;
      $display("FAIL stray_swap_ack actual=1 expected=0");
    end
  end

  // One clock of stimulus; swap_req is a single-cycle pulse.
  task automatic cyc(input logic e, input logic hs, input logic hg, input logic hd,
                     input logic vs, input logic vg, input logic vd, input logic sr = 1'b0);
    ena = e; hsync_i = hs; hgate_i = hg; hdone_i = hd;
    vsync_i = vs; vgate_i = vg; vdone_i = vd; swap_req = sr;
    @(posedge clk);
    #1;
    swap_req = 1'b0;
  endtask

  // One visible line: sync cycle, n active pixels, optional hdone cycle.
  task automatic line(input int n, input bit run, input bit toggle, input bit end_hdone = 1'b1);
    cyc(1, 1, 0, 0, 0, 1, 0);
    check("hsync_out", 32'(hsync), run ? 32'd0 : 32'd1);
    for (int i = 0; i < n; i++) begin
      if (toggle) cyc(0, 0, 1, 0, 0, 1, 0);
      cyc(1, 0, 1, 0, 0, 1, 0);
      if (i == 0) check("blank_out", 32'(blank), run ? 32'd0 : 32'd1);
    end
    if (end_hdone) cyc(1, 0, 0, 1, 0, 1, 0);
  endtask

  task automatic vend(input logic sr = 1'b0);
    cyc(1, 0, 0, 0, 1, 0, 1, sr);
  endtask

  initial begin
    nReset = 1'b1;
    ena = 0; hsync_i = 0; hgate_i = 0; hdone_i = 0;
    vsync_i = 0; vgate_i = 0; vdone_i = 0; swap_req = 0;
    hpol = 1'b1; vpol = 1'b0; cpol = 1'b0;
    bpp = 2'b00; vba0 = 30'h100; vba1 = 30'h800; line_pad = '0;
    #2 nReset = 1'b0;
    #1;
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_word_req", 32'(word_req), 32'd0);
    check("rst_word_addr", 32'(word_addr), 32'd0);
    check("rst_px_x", 32'(px_x), 32'd0);
    check("rst_cur_bank", 32'(cur_bank), 32'd0);
    @(posedge clk); #1;
    nReset = 1'b1;

    // WAIT_FRAME: active pixels before the first vdone fetch nothing.
    line(8, 0, 0);
    vend();
    check("start_word_addr", 32'(word_addr), 32'h100);

    // Frame 1: 8bpp, two lines of 8 pixels.
    exp_req(32'h100, 0, 0); exp_req(32'h101, 4, 0);
    line(8, 1, 0);
    exp_req(32'h102, 0, 1); exp_req(32'h103, 4, 1);
    line(8, 1, 0);
    fq.push_back(2'b00);
    vend();
    check("f1_word_addr", 32'(word_addr), 32'h100);

    // Frame 2: swap requested mid-frame, bank 1 after the frame end.
    exp_req(32'h100, 0, 0); exp_req(32'h101, 4, 0);
    line(8, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 1'b1);
    fq.push_back(2'b11);
    vend();
    check("swap_word_addr", 32'(word_addr), 32'h800);

    // Frame 3: no request, bank stays 1.
    exp_req(32'h800, 0, 0);
    line(4, 1, 0);
    fq.push_back(2'b01);
    vend();

    // Frame 4: second line ends with hdone, vdone and swap_req together.
    exp_req(32'h800, 0, 0);
    line(4, 1, 0);
    exp_req(32'h801, 0, 1);
    line(4, 1, 0, 1'b0);
    fq.push_back(2'b01);
    cyc(1, 0, 0, 1, 1, 0, 1, 1'b1);
    check("coinc_px_x", 32'(px_x), 32'd0);
    check("coinc_px_y", 32'(px_y), 32'd0);
    check("coinc_bank", 32'(cur_bank), 32'd1);

    // Frame 5: the deferred swap lands here.
    exp_req(32'h800, 0, 0);
    line(4, 1, 0);
    fq.push_back(2'b10);
    vend();
    check("f5_word_addr", 32'(word_addr), 32'h100);

    // Frame 6: 16bpp with ena toggling, 6 pixels -> 3 fetches.
    bpp = 2'b01;
    exp_req(32'h100, 0, 0); exp_req(32'h101, 2, 0); exp_req(32'h102, 4, 0);
    line(6, 1, 1);
    fq.push_back(2'b00);
    vend();

`ifdef VGA_VIDADDR_STRIDE_EN
    // Stride: 32bpp, base 0, line_pad 10.
    bpp = 2'b10; vba0 = 30'h0; line_pad = 16'd10;
    fq.push_back(2'b00);
    vend();
    for (int i = 0; i < 4; i++) exp_req(32'(i), 32'(i), 0);
    line(4, 1, 0);
    for (int i = 0; i < 4; i++) exp_req(32'(14 + i), 32'(i), 1);
    line(4, 1, 0);
    bpp = 2'b00; vba0 = 30'h100;
    fq.push_back(2'b00);
    vend();
`endif

    // Mid-frame asynchronous reset.
    exp_req(32'h100, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 1, 0);
    check("pre_rst_px_x", 32'(px_x), 32'd1);
    check("pre_rst_hsync", 32'(hsync), 32'd0);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_hsync", 32'(hsync), 32'd1);
    check("mid_rst_blank", 32'(blank), 32'd1);
    check("mid_rst_word_req", 32'(word_req), 32'd0);
    check("mid_rst_px_x", 32'(px_x), 32'd0);
    @(posedge clk); #1;
    nReset = 1'b1;
    line(4, 0, 0);
    check("wait_blank", 32'(blank), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    check("wq_empty", 32'(wq.size()), 32'd0);
    check("fq_empty", 32'(fq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
